// File: rtl/fifo_pkg.sv
// Shared sizing helpers, parameter legality predicates and the per-cycle
// operation encoding for sync_fifo_thresh and its storage sub-module.
package fifo_pkg;

  // Pointer width for a DEPTH-entry array; a 1-entry array still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one more bit than the pointer so it can reach DEPTH.
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit af_level_ok(input int af_lvl, input int depth);
    return (af_lvl >= 1) && (af_lvl <= depth);
  endfunction

  function automatic bit ae_level_ok(input int ae_lvl, input int depth);
    return (ae_lvl >= 0) && (ae_lvl < depth);
  endfunction

  // Accepted operations in one cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for sync_fifo_thresh: one synchronous write port and a
// read port that is registered by default or asynchronous when FWFT_EN is defined.
module fifo_mem #(
  parameter int WL    = 4,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [WL-1:0] wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [WL-1:0] rdata
);

  logic [WL-1:0] mem [DEPTH];

  // NOTE: the array has no reset; stale words are unreachable because the
  // controller restarts both pointers at 0 and gates reads with EMPTY.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FWFT_EN
  // Head word falls through; the register-port controls are not needed here.
  assign rdata = mem[raddr];

  logic unused_ok;
  assign unused_ok = ^{rst, re};
`else
  // NOTE: non-blocking assignment reads the pre-write word when the read and
  // write addresses collide (full FIFO with simultaneous read and write).
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_thresh.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and a
// sticky clearable error flag. Define FWFT_EN for first-word-fall-through output.
module sync_fifo_thresh
  import fifo_pkg::*;
#(
  parameter int WL     = 4,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wReq,
  input  logic                          rReq,
  input  logic                          clrErr,
  input  logic [WL-1:0]                 din,
  output logic [WL-1:0]                 dout,
  output logic [count_width(DEPTH)-1:0] COUNT,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          AFULL,
  output logic                          AEMPTY,
  output logic                          ERROR
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_thresh: DEPTH must be a power of two and at least 2");
  end
  if (!af_level_ok(AF_LVL, DEPTH)) begin : g_bad_af
    $error("sync_fifo_thresh: AF_LVL must lie in 1..DEPTH");
  end
  if (!ae_level_ok(AE_LVL, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_thresh: AE_LVL must lie in 0..DEPTH-1");
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          error;

  logic rd_ok;
  logic wr_ok;
  logic reject;
  op_e  op;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  assign rd_ok  = rReq && !EMPTY;
  assign wr_ok  = wReq && (!FULL || rd_ok);
  assign reject = (wReq && FULL && !rReq) || (rReq && EMPTY);

  // NOTE: every variable in an always_comb is assigned first, so no latch can form.
  always_comb begin
    op = OP_IDLE;
    op = op_e'({wr_ok, rd_ok});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;

      case (op)
        OP_WRITE: count <= count + 1'b1;
        OP_READ:  count <= count - 1'b1;
        default:  count <= count;
      endcase

      // A fresh rejection outranks a clear arriving in the same cycle.
      if (reject)      error <= 1'b1;
      else if (clrErr) error <= 1'b0;
    end
  end

  fifo_mem #(
    .WL    (WL),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (dout)
  );

  // Flags decode only the registered count, so they change only after CLK.
  assign COUNT  = count;
  assign FULL   = (count == DEPTH_C);
  assign EMPTY  = (count == '0);
  assign AFULL  = (count >= AF_C);
  assign AEMPTY = (count <= AE_C);
  assign ERROR  = error;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh in its default registered-read build: a directed
// vector table, a dout-hold sequence, then random traffic against a queue model.
module tb_sync_fifo_thresh;

  localparam int WL     = 4;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;
  localparam int AE_LVL = 1;

  logic          CLK;
  logic          RST;
  logic          wReq;
  logic          rReq;
  logic          clrErr;
  logic [WL-1:0] din;
  logic [WL-1:0] dout;
  logic [2:0]    COUNT;
  logic          FULL;
  logic          EMPTY;
  logic          AFULL;
  logic          AEMPTY;
  logic          ERROR;

  sync_fifo_thresh #(
    .WL     (WL),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .wReq   (wReq),
    .rReq   (rReq),
    .clrErr (clrErr),
    .din    (din),
    .dout   (dout),
    .COUNT  (COUNT),
    .FULL   (FULL),
    .EMPTY  (EMPTY),
    .AFULL  (AFULL),
    .AEMPTY (AEMPTY),
    .ERROR  (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic          rst;
    logic          w;
    logic          r;
    logic          clr;
    logic [WL-1:0] d;
    int            cnt;
    logic [WL-1:0] exp_dout;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: contents in order, last popped word, sticky error.
  logic [WL-1:0] m_q[$];
  logic [WL-1:0] m_dout;
  logic          m_err;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Flags are derived from the expected occupancy using the threshold rules.
  task automatic check_state(input string tag, input int cnt, input logic [WL-1:0] exp_dout,
                             input logic exp_err);
    check({tag, " COUNT"},  COUNT,  cnt);
    check({tag, " FULL"},   FULL,   (cnt == DEPTH)  ? 1 : 0);
    check({tag, " EMPTY"},  EMPTY,  (cnt == 0)      ? 1 : 0);
    check({tag, " AFULL"},  AFULL,  (cnt >= AF_LVL) ? 1 : 0);
    check({tag, " AEMPTY"}, AEMPTY, (cnt <= AE_LVL) ? 1 : 0);
    check({tag, " ERROR"},  ERROR,  exp_err);
    check({tag, " dout"},   dout,   exp_dout);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic apply(input logic rst, input logic w, input logic r, input logic clr,
                       input logic [WL-1:0] d);
    RST = rst; wReq = w; rReq = r; clrErr = clr; din = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step(input logic rst, input logic w, input logic r, input logic clr,
                            input logic [WL-1:0] d);
    int  size;
    bit  rd_ok;
    bit  wr_ok;
    bit  rej;
    if (rst) begin
      m_q.delete();
      m_dout = '0;
      m_err  = 1'b0;
      return;
    end
    size  = m_q.size();
    rd_ok = r && (size > 0);
    wr_ok = w && ((size < DEPTH) || rd_ok);
    rej   = (w && (size == DEPTH) && !r) || (r && (size == 0));
    if (rd_ok) m_dout = m_q.pop_front();
    if (wr_ok) m_q.push_back(d);
    if (rej)       m_err = 1'b1;
    else if (clr)  m_err = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input logic w, input logic r, input logic clr,
                              input logic [WL-1:0] d, input int cnt,
                              input logic [WL-1:0] exp_dout, input logic exp_err);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.clr = clr; v.d = d;
    v.cnt = cnt; v.exp_dout = exp_dout; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    RST = 1'b1; wReq = 1'b0; rReq = 1'b0; clrErr = 1'b0; din = '0;

    //            rst w  r  clr din   cnt dout err
    tbl.push_back(mk(1, 0, 0, 0, 4'd0, 0, 4'd0, 0));  // reset
    tbl.push_back(mk(0, 1, 0, 0, 4'd1, 1, 4'd0, 0));  // fill 1,2,4,5
    tbl.push_back(mk(0, 1, 0, 0, 4'd2, 2, 4'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd4, 3, 4'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd5, 4, 4'd0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd7, 4, 4'd0, 1));  // overflow, 7 dropped
    tbl.push_back(mk(0, 0, 0, 1, 4'd0, 4, 4'd0, 0));  // clear
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 3, 4'd1, 0));  // drain 1,2,4,5
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 2, 4'd2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 1, 4'd4, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd5, 1));  // underflow, dout holds
    tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 4'd5, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd1, 1, 4'd5, 0));  // refill 1,2,4,5
    tbl.push_back(mk(0, 1, 0, 0, 4'd2, 2, 4'd5, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd4, 3, 4'd5, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'd5, 4, 4'd5, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'd3, 4, 4'd1, 0));  // read+write while full
    tbl.push_back(mk(0, 1, 1, 0, 4'd1, 4, 4'd2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 3, 4'd4, 0));  // drain across wrap
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 2, 4'd5, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 1, 4'd3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'd2, 1, 4'd1, 1));  // both while empty
    tbl.push_back(mk(0, 0, 1, 1, 4'd0, 0, 4'd2, 0));  // read returns 2, clear
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd2, 1));  // set error before reset
    tbl.push_back(mk(0, 1, 0, 0, 4'd6, 1, 4'd2, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'd7, 2, 4'd2, 1));
    tbl.push_back(mk(0, 1, 0, 0, 4'd8, 3, 4'd2, 1));
    tbl.push_back(mk(1, 1, 0, 0, 4'd15, 0, 4'd0, 0)); // reset beats write
    tbl.push_back(mk(0, 1, 0, 0, 4'd9, 1, 4'd0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd9, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'd0, 0, 4'd9, 1));  // new error beats clear
    tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 4'd9, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].clr, tbl[i].d);
      check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].exp_dout, tbl[i].exp_err);
    end

    // dout must hold across idle cycles and across a write that is not read.
    apply(0, 1, 0, 0, 4'd11);
    apply(0, 0, 0, 0, 4'd0);
    apply(0, 0, 0, 0, 4'd0);
    check_state("hold", 1, 4'd9, 0);
    apply(0, 0, 1, 0, 4'd0);
    check_state("hold_pop", 0, 4'd11, 0);

    // Random traffic; the read/write bias swings every 40 cycles to reach both ends.
    apply(1, 0, 0, 0, 4'd0);
    model_step(1, 0, 0, 0, 4'd0);
    for (int c = 0; c < 600; c++) begin
      logic          rst_r;
      logic          w_r;
      logic          r_r;
      logic          clr_r;
      logic [WL-1:0] d_r;
      int            wbias;
      wbias = ((c / 40) % 2 == 0) ? 70 : 30;
      rst_r = ($urandom_range(0, 99) < 1);
      w_r   = ($urandom_range(0, 99) < wbias);
      r_r   = ($urandom_range(0, 99) < (100 - wbias));
      clr_r = ($urandom_range(0, 99) < 6);
      d_r   = WL'($urandom);
      apply(rst_r, w_r, r_r, clr_r, d_r);
      model_step(rst_r, w_r, r_r, clr_r, d_r);
      check_state($sformatf("rand%0d", c), m_q.size(), m_dout, m_err);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_thresh.md
# sync_fifo_thresh

Parametrised synchronous FIFO, the next-generation replacement for the basic queue. Adds an occupancy count, programmable almost-full and almost-empty thresholds, simultaneous read/write at the full boundary, and a sticky, clearable error flag. It sits between a producer and a consumer in the same clock domain and buffers words of width WL.

## Interface
- WL, 4: data word width in bits (≥1)
- DEPTH, 4: number of entries; power of two, ≥2
- AF_LVL, DEPTH-1: AFULL asserts when COUNT ≥ AF_LVL (1..DEPTH)
- AE_LVL, 1: AEMPTY asserts when COUNT ≤ AE_LVL (0..DEPTH-1)

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- wReq  in  1  write request
- rReq  in  1  read request
- clrErr  in  1  clears ERROR
- din  in  WL  write data
- dout  out  WL  read data
- COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- AFULL  out  1  COUNT ≥ AF_LVL
- AEMPTY  out  1  COUNT ≤ AE_LVL
- ERROR  out  1  sticky overflow/underflow flag

## Operation
- Storage: DEPTH×WL array. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. COUNT is a separate register.
- Read accepted = rReq && !EMPTY.
- Write accepted = wReq && (!FULL || read accepted). When FULL and both are requested, both are accepted and COUNT stays at DEPTH.
- When EMPTY and both are requested, the write is accepted and the read is rejected. COUNT becomes 1 and ERROR sets.
- COUNT update: +1 on a write alone, −1 on a read alone, unchanged on both or neither.
- Rejected operations move no pointer and change no memory.
- ERROR sets at the edge after any rejected request: (wReq && FULL && !rReq) or (rReq && EMPTY).
  - It stays set until RST or clrErr.
  - A new error in the same cycle as clrErr wins, so ERROR stays 1.
- Flags are decoded combinationally from the registered COUNT and never glitch relative to CLK.
- Reset values: pointers 0, COUNT 0, EMPTY 1, FULL 0, AEMPTY 1, AFULL 0 (or 1 only if AF_LVL is 0, which is illegal), ERROR 0, dout 0. Memory contents are not cleared.
- Reset mid-operation discards all entries. Stale memory is never returned, because pointers restart at 0 and reads are gated by EMPTY.

## Timing
- Write sampled at edge N: EMPTY deasserts after N, and a read may be sampled at N+1.
- Read sampled at edge N (registered mode): dout shows the head word after edge N. dout holds its value when no read is accepted, including on a rejected read.
- COUNT and flags reflect the operations sampled at edge N immediately after N.
- There is no other pipeline latency. Throughput is one write and one read per cycle.

## Configuration
- FWFT_EN defined: first-word-fall-through mode.
  - dout is driven combinationally from mem[rptr]; the head word is visible while EMPTY=0 without a read.
  - rReq acts as a pop, and the next word appears after the edge.
  - dout is don't-care while EMPTY=1.
  - Write-to-dout latency is 1 edge.
- FWFT_EN undefined: registered read as described in Timing.
  - dout reset 0.
  - Write-to-dout latency is 2 edges (write, then read).

## Structure
- Package fifo_pkg holds:
  - the pointer-width helper function (clog2-based)
  - the COUNT width constant expression
  - parameter legality checks: DEPTH power of two, AF_LVL/AE_LVL in range
- Sub-module fifo_mem: simple dual-port array.
  - One synchronous write port.
  - Read port is registered or asynchronous, selected by FWFT_EN.
  - Holds no control logic.

## Test plan
All scenarios use WL=4, DEPTH=4, AF_LVL=3, AE_LVL=1.
- Reset, write 1,2,4,5 on consecutive cycles -> COUNT 1,2,3,4; AEMPTY drops at COUNT=2; AFULL rises at COUNT=3; FULL at COUNT=4; ERROR=0.
- While FULL, write 7 alone -> COUNT stays 4, ERROR=1 next edge; pulse clrErr -> ERROR=0; later reads show 7 was never stored.
- Read four times -> dout 1,2,4,5 in order, EMPTY=1 after the last read; fifth read -> ERROR=1, dout holds 5, COUNT stays 0.
- Fill to 4, then read+write 3 together, then read+write 1 together -> COUNT stays 4; draining returns 4,5,3,1 (order kept across pointer wrap).
- EMPTY with rReq=wReq=1, din=2 -> COUNT=1, ERROR=1; the next read returns 2.
- With COUNT=3, assert RST for one cycle -> COUNT=0, EMPTY=1, ERROR=0, dout=0 (registered mode); write 9 then read -> dout=9.
